lane_sync_deser: RTL and testbench

LANE_SYNC_DESER -- requirements
Module: lane_sync_deser

---
 rtl/lane_sync_deser.sv | 139 +++++++++++++
 tb/tb_lane_sync_deser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lane_sync_deser.sv
// Multi-lane serial deserializer: comma-based frame alignment, odd-parity checking
// and per-lane HUNT/LOCKING/SYNC state with registered payload, valid, error and active outputs.
module lane_sync_deser #(
  parameter int unsigned          DATA_SIZE  = 8,
  parameter int unsigned          LANES      = 2,
  parameter logic [DATA_SIZE-1:0] COMMA      = DATA_SIZE'(8'hBC),
  parameter int unsigned          SYNC_COUNT = 4,
  parameter int unsigned          ERR_LIMIT  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES-1:0]             serial_in,
  output logic [LANES*DATA_SIZE-1:0]   data_out,
  output logic [LANES-1:0]             valid_out,
  output logic [LANES-1:0]             active,
  output logic [LANES-1:0]             error_out
);

  localparam int unsigned FRAME_W = DATA_SIZE + 1;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);
  localparam int unsigned LIM_W   = 4;

  localparam logic [FRAME_W-1:0] COMMA_FRAME = {COMMA, ~^COMMA};
  localparam logic [CNT_W-1:0]   LAST_BIT    = CNT_W'(DATA_SIZE);
  localparam logic [LIM_W-1:0]   SYNC_CNT    = LIM_W'(SYNC_COUNT);
  localparam logic [LIM_W-1:0]   ERR_LIM     = LIM_W'(ERR_LIMIT);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    SYNC    = 2'd2
  } lane_state_e;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_state_e          state;
    logic [FRAME_W-1:0]   shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [LIM_W-1:0]     comma_cnt;
    logic [LIM_W-1:0]     err_cnt;
    logic [DATA_SIZE-1:0] data_q;
    logic                 valid_q;
    logic                 active_q;
    logic                 err_q;

    logic boundary;
    logic is_comma;
    logic parity_ok;

    // shreg holds the frame completed on the previous edge; it is judged one edge later
    assign boundary  = (bit_cnt == LAST_BIT);
    assign is_comma  = (shreg == COMMA_FRAME);
    assign parity_ok = ^shreg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state     <= HUNT;
        shreg     <= '0;
        bit_cnt   <= '0;
        comma_cnt <= '0;
        err_cnt   <= '0;
        data_q    <= '0;
        valid_q   <= 1'b0;
        active_q  <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        shreg   <= {shreg[FRAME_W-2:0], serial_in[i]};
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        bit_cnt <= boundary ? '0 : bit_cnt + CNT_W'(1);

        case (state)
          HUNT: begin
            if (is_comma) begin
              bit_cnt   <= '0;
              comma_cnt <= LIM_W'(1);
              err_cnt   <= '0;
              if (SYNC_CNT == LIM_W'(1)) begin
                state    <= SYNC;
                active_q <= 1'b1;
              end else begin
                state <= LOCKING;
              end
            end
          end

          LOCKING: begin
            if (boundary) begin
              if (is_comma) begin
                comma_cnt <= comma_cnt + LIM_W'(1);
                if (comma_cnt + LIM_W'(1) == SYNC_CNT) begin
                  state    <= SYNC;
                  active_q <= 1'b1;
                end
              end else begin
                state     <= HUNT;
                comma_cnt <= '0;
                bit_cnt   <= '0;
              end
            end
          end

          SYNC: begin
            if (boundary) begin
              if (is_comma) begin
                err_cnt <= '0;
              end else if (parity_ok) begin
                data_q  <= shreg[FRAME_W-1:1];
                valid_q <= 1'b1;
                err_cnt <= '0;
              end else begin
                err_q <= 1'b1;
                if (err_cnt + LIM_W'(1) == ERR_LIM) begin
                  state     <= HUNT;
                  active_q  <= 1'b0;
                  err_cnt   <= '0;
                  comma_cnt <= '0;
                  bit_cnt   <= '0;
                end else begin
                  err_cnt <= err_cnt + LIM_W'(1);
                end
              end
            end
          end

          default: begin
            state    <= HUNT;
            active_q <= 1'b0;
          end
        endcase
      end
    end

    assign data_out[i*DATA_SIZE +: DATA_SIZE] = data_q;
    assign valid_out[i] = valid_q;
    assign active[i]    = active_q;
    assign error_out[i] = err_q;
  end

endmodule

// File: tb/tb_lane_sync_deser.sv
// Directed bench for lane_sync_deser at default parameters: each frame's first bit
// cycle is where the previous frame's boundary results become visible.
module tb_lane_sync_deser;

  logic        clk;
  logic        reset;
  logic [1:0]  serial_in;
  logic [15:0] data_out;
  logic [1:0]  valid_out;
  logic [1:0]  active;
  logic [1:0]  error_out;

  int vectors = 0;
  int fails   = 0;

  // 0xBC has five ones, so its odd-parity bit is 0
  localparam logic [8:0] C    = {8'hBC, 1'b0};
  localparam logic [8:0] P55  = 9'h0AB;
  localparam logic [8:0] B55  = 9'h0AA;
  localparam logic [8:0] PA5  = 9'h14B;
  localparam logic [8:0] P3C  = 9'h079;
  localparam logic [8:0] P00  = 9'h001;
  localparam logic [8:0] Z    = 9'h000;
  localparam logic [8:0] N1   = 9'h155;
  localparam logic [8:0] N2   = 9'h0AA;

  lane_sync_deser dut (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serial_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .error_out (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step(input logic b0, input logic b1);
    serial_in = {b1, b0};
    @(posedge clk);
    #1;
  endtask

  // Sends one frame per lane; checks boundary results of the previous frame on the first bit
  task automatic frame_chk(input string nm, input logic [8:0] f0, input logic [8:0] f1,
                           input logic [1:0] ev, input logic [1:0] ee, input logic [1:0] ea,
                           input logic [15:0] ed);
    int extra;
    extra = 0;
    step(f0[8], f1[8]);
    vectors++;
    if ({valid_out, error_out, active, data_out} !== {ev, ee, ea, ed}) begin
      fails++;
      $display("FAIL %s: got v=%b e=%b a=%b d=%h, want v=%b e=%b a=%b d=%h",
               nm, valid_out, error_out, active, data_out, ev, ee, ea, ed);
    end
    for (int k = 7; k >= 0; k--) begin
      step(f0[k], f1[k]);
      if ((valid_out | error_out) !== 2'b00) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL %s_midframe: got %0d stray pulse cycles, want 0", nm, extra);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    serial_in = 2'b00;
    repeat (3) step(1'b0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(i[0], ~i[0]);
      vectors++;
      if ({valid_out, error_out, active, data_out} !== 22'h0) begin
        fails++;
        $display("FAIL reset_hold%0d: got v=%b e=%b a=%b d=%h, want all 0",
                 i, valid_out, error_out, active, data_out);
      end
    end
    reset = 1'b1;
    frame_chk("reset_rel0", P55, P55, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("reset_rel1", P55, P55, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("reset_rel2", Z,   Z,   2'b00, 2'b00, 2'b00, 16'h0000);
  endtask

  task automatic lock_and_deliver(input string nm);
    frame_chk({nm, "_c1"}, C,   Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk({nm, "_c2"}, C,   Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk({nm, "_c3"}, C,   Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk({nm, "_c4"}, C,   Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk({nm, "_act"}, P55, Z, 2'b00, 2'b00, 2'b01, 16'h0000);
    frame_chk({nm, "_val"}, C,   Z, 2'b01, 2'b00, 2'b01, 16'h0055);
    frame_chk({nm, "_strip"}, C, Z, 2'b00, 2'b00, 2'b01, 16'h0055);
    frame_chk({nm, "_hold"}, Z,  Z, 2'b00, 2'b00, 2'b01, 16'h0055);
  endtask

  task automatic test_lock();
    do_reset();
    lock_and_deliver("lock");
  endtask

  task automatic test_offset();
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    lock_and_deliver("offset");
  endtask

  task automatic test_lock_abort();
    do_reset();
    frame_chk("abort_c1",  C,   Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("abort_c2",  C,   Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("abort_p00", P00, Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("abort_r1",  C,   Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("abort_r2",  C,   Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("abort_r3",  C,   Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("abort_r4",  C,   Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("abort_act", P55, Z, 2'b00, 2'b00, 2'b01, 16'h0000);
    frame_chk("abort_val", C,   Z, 2'b01, 2'b00, 2'b01, 16'h0055);
  endtask

  task automatic test_errors();
    do_reset();
    for (int i = 0; i < 4; i++)
      frame_chk("err_lock", C, Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("err_b1",   B55, Z, 2'b00, 2'b00, 2'b01, 16'h0000);
    frame_chk("err_b2",   B55, Z, 2'b00, 2'b01, 2'b01, 16'h0000);
    frame_chk("err_b3",   B55, Z, 2'b00, 2'b01, 2'b01, 16'h0000);
    frame_chk("err_drop", C,   Z, 2'b00, 2'b01, 2'b00, 16'h0000);
    frame_chk("err_rl2",  C,   Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("err_rl3",  C,   Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("err_rl4",  C,   Z, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("err_s1",   B55, Z, 2'b00, 2'b00, 2'b01, 16'h0000);
    frame_chk("err_s2",   B55, Z, 2'b00, 2'b01, 2'b01, 16'h0000);
    frame_chk("err_good", PA5, Z, 2'b00, 2'b01, 2'b01, 16'h0000);
    frame_chk("err_a5",   B55, Z, 2'b01, 2'b00, 2'b01, 16'h00A5);
    frame_chk("err_s3",   B55, Z, 2'b00, 2'b01, 2'b01, 16'h00A5);
    frame_chk("err_s4",   C,   Z, 2'b00, 2'b01, 2'b01, 16'h00A5);
    frame_chk("err_keep", C,   Z, 2'b00, 2'b00, 2'b01, 16'h00A5);
  endtask

  task automatic test_lanes();
    do_reset();
    frame_chk("ln_c1",  N1, C,   2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("ln_c2",  N2, C,   2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("ln_c3",  N1, C,   2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("ln_c4",  N2, C,   2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("ln_act", N1, P3C, 2'b00, 2'b00, 2'b10, 16'h0000);
    frame_chk("ln_v1",  N2, P3C, 2'b10, 2'b00, 2'b10, 16'h3C00);
    frame_chk("ln_v2",  N1, P3C, 2'b10, 2'b00, 2'b10, 16'h3C00);
    for (int k = 8; k >= 5; k--) step(N2[k], P3C[k]);
    reset = 1'b0;
    #1;
    vectors++;
    if ({valid_out, error_out, active, data_out} !== 22'h0) begin
      fails++;
      $display("FAIL ln_async_reset: got v=%b e=%b a=%b d=%h, want all 0",
               valid_out, error_out, active, data_out);
    end
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    reset = 1'b1;
    frame_chk("ln_post1", N1, P3C, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("ln_post2", N2, P3C, 2'b00, 2'b00, 2'b00, 16'h0000);
    for (int i = 0; i < 4; i++)
      frame_chk("ln_rc", N1, C, 2'b00, 2'b00, 2'b00, 16'h0000);
    frame_chk("ln_ract", N2, P3C, 2'b00, 2'b00, 2'b10, 16'h0000);
    frame_chk("ln_rval", N1, P3C, 2'b10, 2'b00, 2'b10, 16'h3C00);
  endtask

  initial begin
    reset = 1'b0;
    serial_in = 2'b00;
    #1;
    vectors++;
    if ({valid_out, error_out, active, data_out} !== 22'h0) begin
      fails++;
      $display("FAIL power_on_reset: got v=%b e=%b a=%b d=%h, want all 0",
               valid_out, error_out, active, data_out);
    end
    test_reset();
    test_lock();
    test_offset();
    test_lock_abort();
    test_errors();
    test_lanes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
